ysyx_22050019_axi_arbiter: RTL
==============================

Name: ysyx_22050019_axi_arbiter

Overview:
Two-master to one-slave AXI arbiter placed in front of the LSU/SRAM AXI slave. The IFU master (m0) is read-only and the LSU master (m1) is read/write, so the single SRAM model serves both instruction fetch and data access. Read transactions are arbitrated round-robin, one outstanding read at a time. The write channels (AW/W/B) belong to the LSU only and are forwarded straight through.

Parameters:
AXI_DATA_WIDTH, 64, data bus width.
AXI_ADDR_WIDTH, 64, address bus width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
m0_ar_valid  in  1  IFU read address valid
m0_ar_ready  out  1  IFU read address ready
m0_ar_addr  in  AXI_ADDR_WIDTH  IFU read address
m0_r_valid  out  1  IFU read data valid
m0_r_ready  in  1  IFU read data ready
m0_r_resp  out  2  IFU read response
m0_r_data  out  AXI_DATA_WIDTH  IFU read data
m1_ar_valid / m1_ar_ready / m1_ar_addr / m1_r_valid / m1_r_ready / m1_r_resp / m1_r_data  same as m0_*, for the LSU
m1_aw_valid  in  1 / m1_aw_ready  out  1 / m1_aw_addr  in  AXI_ADDR_WIDTH  LSU write address
m1_w_valid  in  1 / m1_w_ready  out  1 / m1_w_data  in  AXI_DATA_WIDTH / m1_w_strb  in  AXI_DATA_WIDTH/8  LSU write data
m1_b_valid  out  1 / m1_b_ready  in  1 / m1_b_resp  out  2  LSU write response
s_ar_valid  out  1 / s_ar_ready  in  1 / s_ar_addr  out  AXI_ADDR_WIDTH  slave read address
s_r_valid  in  1 / s_r_ready  out  1 / s_r_resp  in  2 / s_r_data  in  AXI_DATA_WIDTH  slave read data
s_aw_valid  out  1 / s_aw_ready  in  1 / s_aw_addr  out  AXI_ADDR_WIDTH  slave write address
s_w_valid  out  1 / s_w_ready  in  1 / s_w_data  out  AXI_DATA_WIDTH / s_w_strb  out  AXI_DATA_WIDTH/8  slave write data
s_b_valid  in  1 / s_b_ready  out  1 / s_b_resp  in  2  slave write response

Behaviour:
- Registered state: FSM state {IDLE, AR, R}, grant (0=m0, 1=m1), last (the master served last).
- Reset: state=IDLE, grant=0, last=1, so m0 wins the first tie.
- All read-channel outputs are combinational decodes of state and grant. In IDLE they are all 0.
- IDLE:
  - No ar_valid asserted: stay in IDLE.
  - Exactly one ar_valid: grant that master, go to AR.
  - Both asserted: grant = ~last, go to AR.
  - No address is forwarded in the decision cycle, so arbitration costs 1 cycle.
- AR:
  - s_ar_valid = granted ar_valid, s_ar_addr = granted ar_addr, granted ar_ready = s_ar_ready.
  - Non-granted ar_ready=0.
  - On s_ar_valid & s_ar_ready: go to R.
  - If the granted master drops ar_valid, stay in AR with no re-arbitration.
- R:
  - Granted r_valid/r_resp/r_data = s_r_*, s_r_ready = granted r_ready.
  - Non-granted r_valid=0, r_resp=0, r_data=0.
  - On s_r_valid & s_r_ready: last <= grant, go to IDLE.
  - A new request is considered no earlier than the next IDLE cycle, so back-to-back reads have a minimum 1-cycle gap.
- A request arriving in AR/R from the non-granted master waits; its ar_ready stays 0.
- Write path:
  - Pure combinational pass-through, m1_aw_* <-> s_aw_*, m1_w_* <-> s_w_*, s_b_* <-> m1_b_*.
  - Independent of the read FSM; concurrent read and write are allowed.
- Reset asserted mid-transaction: FSM returns to IDLE next cycle and the in-flight read is abandoned. The slave is reset by the same rst.
- Reads are single-beat only; there are no ID, len or burst signals.

Test Plan:
- Reset, then m0 ar_valid=1, addr=0x8000_0000 -> 1 IDLE cycle, then s_ar_addr=0x8000_0000. m0 gets r_data from the slave; m1_r_valid stays 0 throughout.
- m0 and m1 ar_valid rise in the same cycle after reset, m0 addr 0x8000_0000, m1 addr 0x8000_0100 -> m0 is served first, then m1. With both requesting again, m0 is served next (alternation).
- m1 requests while m0 is in R with m0_r_ready held 0 for 3 cycles -> m1_ar_ready=0 until m0's R handshake. m1 is granted in the following IDLE cycle.
- m1 write aw=0x8000_0010, w_data=0xDEAD_BEEF_0000_0001, strb=0xFF, concurrent with an m0 read -> both complete. A later m1 read of 0x8000_0010 returns the written data.
- Assert rst for 1 cycle while in R -> next cycle state=IDLE, every ar_ready/r_valid output=0. A new m1 read then completes normally.
- s_ar_ready held 0 for 4 cycles in AR -> s_ar_valid/s_ar_addr stay stable and the grant is unchanged throughout.

Source files
------------

// File: rtl/ysyx_22050019_axi_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22050019_axi_arbiter
// Two-master / one-slave AXI arbiter placed in front of the LSU/SRAM slave.
//   m0 : IFU, read-only
//   m1 : LSU, read/write
// Reads are single-beat and are arbitrated round-robin, with one read
// outstanding at a time. The m1 write channels (AW/W/B) bypass the read FSM
// and connect straight to the slave, so a write can overlap a read.
// ----------------------------------------------------------------------------
module ysyx_22050019_axi_arbiter #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,

  // m0 : IFU read channels
  input  logic                          m0_ar_valid,
  output logic                          m0_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]     m0_ar_addr,
  output logic                          m0_r_valid,
  input  logic                          m0_r_ready,
  output logic [1:0]                    m0_r_resp,
  output logic [AXI_DATA_WIDTH-1:0]     m0_r_data,

  // m1 : LSU read channels
  input  logic                          m1_ar_valid,
  output logic                          m1_ar_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]     m1_ar_addr,
  output logic                          m1_r_valid,
  input  logic                          m1_r_ready,
  output logic [1:0]                    m1_r_resp,
  output logic [AXI_DATA_WIDTH-1:0]     m1_r_data,

  // m1 : LSU write channels
  input  logic                          m1_aw_valid,
  output logic                          m1_aw_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]     m1_aw_addr,
  input  logic                          m1_w_valid,
  output logic                          m1_w_ready,
  input  logic [AXI_DATA_WIDTH-1:0]     m1_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   m1_w_strb,
  output logic                          m1_b_valid,
  input  logic                          m1_b_ready,
  output logic [1:0]                    m1_b_resp,

  // slave read channels
  output logic                          s_ar_valid,
  input  logic                          s_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0]     s_ar_addr,
  input  logic                          s_r_valid,
  output logic                          s_r_ready,
  input  logic [1:0]                    s_r_resp,
  input  logic [AXI_DATA_WIDTH-1:0]     s_r_data,

  // slave write channels
  output logic                          s_aw_valid,
  input  logic                          s_aw_ready,
  output logic [AXI_ADDR_WIDTH-1:0]     s_aw_addr,
  output logic                          s_w_valid,
  input  logic                          s_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]     s_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0]   s_w_strb,
  input  logic                          s_b_valid,
  output logic                          s_b_ready,
  input  logic [1:0]                    s_b_resp
);

  // IDLE : arbitration cycle, nothing forwarded
  // AR   : granted master's address channel connected to the slave
  // R    : granted master's data channel connected to the slave
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  logic   r_grant;       // 0 = m0, 1 = m1
  logic   w_grant_nxt;
  logic   r_last;        // master that completed the most recent read
  logic   w_last_nxt;

  logic   w_ar_hs;
  logic   w_r_hs;

  // Round-robin pick: a lone requester wins, a tie goes to the master that
  // was not served last.
  function automatic logic pick_grant(input logic req0, input logic req1,
                                      input logic last);
    logic sel;
    if (req0 && req1) begin
      sel = ~last;
    end else if (req1) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    return sel;
  endfunction

  assign w_ar_hs = s_ar_valid & s_ar_ready;
  assign w_r_hs  = s_r_valid  & s_r_ready;

  // State, grant and round-robin history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;   // m0 wins the first tie after reset
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state logic: grant is only updated in IDLE and held until the R
  // handshake, so a master dropping ar_valid in AR never re-arbitrates.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (m0_ar_valid || m1_ar_valid) begin
          w_grant_nxt = pick_grant(m0_ar_valid, m1_ar_valid, r_last);
          w_state_nxt = ST_AR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_AR: begin
        if (w_ar_hs) begin
          w_state_nxt = ST_R;
        end else begin
          w_state_nxt = ST_AR;
        end
      end
      ST_R: begin
        if (w_r_hs) begin
          w_last_nxt  = r_grant;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_R;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read-channel routing: pure decode of state and grant, everything zero
  // unless the granted master is connected in AR or R.
  always_comb begin
    s_ar_valid  = 1'b0;
    s_ar_addr   = {AXI_ADDR_WIDTH{1'b0}};
    s_r_ready   = 1'b0;
    m0_ar_ready = 1'b0;
    m1_ar_ready = 1'b0;
    m0_r_valid  = 1'b0;
    m0_r_resp   = 2'b00;
    m0_r_data   = {AXI_DATA_WIDTH{1'b0}};
    m1_r_valid  = 1'b0;
    m1_r_resp   = 2'b00;
    m1_r_data   = {AXI_DATA_WIDTH{1'b0}};
    case (r_state)
      ST_IDLE: begin
        s_ar_valid = 1'b0;
      end
      ST_AR: begin
        if (r_grant) begin
          s_ar_valid  = m1_ar_valid;
          s_ar_addr   = m1_ar_addr;
          m1_ar_ready = s_ar_ready;
        end else begin
          s_ar_valid  = m0_ar_valid;
          s_ar_addr   = m0_ar_addr;
          m0_ar_ready = s_ar_ready;
        end
      end
      ST_R: begin
        if (r_grant) begin
          m1_r_valid = s_r_valid;
          m1_r_resp  = s_r_resp;
          m1_r_data  = s_r_data;
          s_r_ready  = m1_r_ready;
        end else begin
          m0_r_valid = s_r_valid;
          m0_r_resp  = s_r_resp;
          m0_r_data  = s_r_data;
          s_r_ready  = m0_r_ready;
        end
      end
      default: begin
        s_ar_valid = 1'b0;
      end
    endcase
  end

  // Write path belongs to the LSU only: straight wiring, no state.
  assign s_aw_valid  = m1_aw_valid;
  assign s_aw_addr   = m1_aw_addr;
  assign m1_aw_ready = s_aw_ready;
  assign s_w_valid   = m1_w_valid;
  assign s_w_data    = m1_w_data;
  assign s_w_strb    = m1_w_strb;
  assign m1_w_ready  = s_w_ready;
  assign m1_b_valid  = s_b_valid;
  assign m1_b_resp   = s_b_resp;
  assign s_b_ready   = m1_b_ready;

endmodule
